// File: rtl/nav_pkg.sv
// nav_pkg: direction encoding and source-count constants shared by the scheduler and the odometry datapath
package nav_pkg;
    typedef enum logic [1:0] {
        DIR_PX = 2'd0,
        DIR_PY = 2'd1,
        DIR_NX = 2'd2,
        DIR_NY = 2'd3
    } nav_dir_t;
    localparam int NUM_SPIKE_CH = 4;
    localparam int NUM_SRC = 5;
    localparam int SRC_CMD = 4;
endpackage

// File: rtl/nav_rr_arbiter.sv
// nav_rr_arbiter: N-input round-robin arbiter with one-hot grant; pointer moves past each winner
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector (already masked by the caller)
//   gnt        : one-hot grant, zero when no request
//   gnt_idx    : index of the granted source
module nav_rr_arbiter #(
    parameter int N = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic any;
    // Scan from farthest to nearest so the source closest to the pointer wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                any = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt = any ? N'(1) << gnt_idx : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (any)
            ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
endmodule

// File: rtl/nav_update_scheduler.sv
// nav_update_scheduler: counts spike edges per channel and round-robins spike and host-command updates into the accumulator
//   clk, rst_n                  : clock, asynchronous active-low reset
//   enable                      : 1 permits grants; 0 freezes arbitration while counting continues
//   spike_in                    : spike levels, bit0 +X, bit1 +Y, bit2 -X, bit3 -Y
//   cmd_valid/dir/step, ready   : host move command, consumed when cmd_ready is high
//   upd_valid/ready/dir/step/src: update transaction to the accumulator
//   overflow, clr_overflow      : sticky per-channel spike-loss flags, write-1-to-clear
//   busy                        : transaction in flight or any spike pending
module nav_update_scheduler
    import nav_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [3:0]        spike_in,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_dir,
    input  logic [STEP_W-1:0] cmd_step,
    output logic              cmd_ready,
    output logic              upd_valid,
    input  logic              upd_ready,
    output logic [1:0]        upd_dir,
    output logic [STEP_W-1:0] upd_step,
    output logic [2:0]        upd_src,
    output logic [3:0]        overflow,
    input  logic [3:0]        clr_overflow,
    output logic              busy
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [NUM_SPIKE_CH-1:0][CNT_W-1:0] cnt;
    logic [NUM_SPIKE_CH-1:0] prev, rise, sat, nz, ovf_set;
    logic [NUM_SRC-1:0] req, gnt;
    logic [2:0] gnt_idx;
    logic slot_free, cmd_gnt, issue;
    always_comb begin
        for (int i = 0; i < NUM_SPIKE_CH; i++) begin
            sat[i] = cnt[i] == CNT_MAX;
            nz[i] = |cnt[i];
        end
    end
    assign rise = spike_in & ~prev;
    assign slot_free = ~upd_valid | upd_ready;
    assign req = {cmd_valid, nz} & {NUM_SRC{enable & slot_free}};
    assign cmd_gnt = gnt[SRC_CMD];
    assign cmd_ready = cmd_gnt;
    // A zero-step command is consumed but never presented downstream.
    assign issue = (|gnt) && !(cmd_gnt && cmd_step == '0);
    // A rise on a saturated channel is lost unless a grant frees a slot that same cycle.
    assign ovf_set = rise & ~gnt[NUM_SPIKE_CH-1:0] & sat;
    assign busy = upd_valid | (|nz);
    nav_rr_arbiter #(.N(NUM_SRC)) u_arb (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .gnt(gnt),
        .gnt_idx(gnt_idx)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            cnt <= '0;
            overflow <= '0;
            upd_valid <= 1'b0;
            upd_dir <= '0;
            upd_step <= '0;
            upd_src <= '0;
        end else begin
            prev <= spike_in;
            for (int i = 0; i < NUM_SPIKE_CH; i++) begin
                if (rise[i] && !gnt[i] && !sat[i])
                    cnt[i] <= cnt[i] + 1'b1;
                else if (!rise[i] && gnt[i])
                    cnt[i] <= cnt[i] - 1'b1;
            end
            overflow <= (overflow & ~clr_overflow) | ovf_set;
            if (slot_free) begin
                upd_valid <= issue;
                if (issue) begin
                    upd_src <= gnt_idx;
                    upd_dir <= cmd_gnt ? cmd_dir : gnt_idx[1:0];
                    upd_step <= cmd_gnt ? cmd_step : STEP_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_nav_update_scheduler.sv
// tb_nav_update_scheduler: table-driven and directed checks of the navigation update scheduler
module tb_nav_update_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic [3:0] spike_in = '0;
    logic cmd_valid = 1'b0;
    logic [1:0] cmd_dir = '0;
    logic [15:0] cmd_step = '0;
    logic cmd_ready;
    logic upd_valid;
    logic upd_ready = 1'b0;
    logic [1:0] upd_dir;
    logic [15:0] upd_step;
    logic [2:0] upd_src;
    logic [3:0] overflow;
    logic [3:0] clr_overflow = '0;
    logic busy;
    int tests = 0;
    int fails = 0;
    typedef struct packed {
        logic [3:0] spk;
        logic cv;
        logic [1:0] cdir;
        logic [15:0] cstep;
        logic rdy;
        logic ev;
        logic [2:0] esrc;
        logic [1:0] edir;
        logic [15:0] estep;
        logic ecr;
        logic ebusy;
    } vec_t;
    vec_t tbl [12];
    int rr_exp [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    nav_update_scheduler #(.CNT_W(4), .STEP_W(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .spike_in(spike_in),
        .cmd_valid(cmd_valid),
        .cmd_dir(cmd_dir),
        .cmd_step(cmd_step),
        .cmd_ready(cmd_ready),
        .upd_valid(upd_valid),
        .upd_ready(upd_ready),
        .upd_dir(upd_dir),
        .upd_step(upd_step),
        .upd_src(upd_src),
        .overflow(overflow),
        .clr_overflow(clr_overflow),
        .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        int n, n0, n4, nval;
        tbl[0]  = '{4'b0010, 1'b0, 2'd0, 16'd0,   1'b1, 1'b0, 3'd0, 2'd0, 16'd0,   1'b0, 1'b0};
        tbl[1]  = '{4'b0000, 1'b0, 2'd0, 16'd0,   1'b1, 1'b0, 3'd0, 2'd0, 16'd0,   1'b0, 1'b1};
        tbl[2]  = '{4'b0000, 1'b0, 2'd0, 16'd0,   1'b1, 1'b1, 3'd1, 2'd1, 16'd1,   1'b0, 1'b1};
        tbl[3]  = '{4'b0000, 1'b1, 2'd0, 16'd0,   1'b1, 1'b0, 3'd0, 2'd0, 16'd0,   1'b1, 1'b0};
        tbl[4]  = '{4'b1000, 1'b0, 2'd0, 16'd0,   1'b1, 1'b0, 3'd0, 2'd0, 16'd0,   1'b0, 1'b0};
        tbl[5]  = '{4'b0000, 1'b0, 2'd0, 16'd0,   1'b1, 1'b0, 3'd0, 2'd0, 16'd0,   1'b0, 1'b1};
        tbl[6]  = '{4'b0000, 1'b1, 2'd2, 16'd300, 1'b1, 1'b1, 3'd3, 2'd3, 16'd1,   1'b1, 1'b1};
        tbl[7]  = '{4'b0000, 1'b0, 2'd0, 16'd0,   1'b0, 1'b1, 3'd4, 2'd2, 16'd300, 1'b0, 1'b1};
        tbl[8]  = '{4'b0000, 1'b1, 2'd1, 16'd7,   1'b0, 1'b1, 3'd4, 2'd2, 16'd300, 1'b0, 1'b1};
        tbl[9]  = '{4'b0000, 1'b1, 2'd1, 16'd7,   1'b1, 1'b1, 3'd4, 2'd2, 16'd300, 1'b1, 1'b1};
        tbl[10] = '{4'b0000, 1'b0, 2'd0, 16'd0,   1'b1, 1'b1, 3'd4, 2'd1, 16'd7,   1'b0, 1'b1};
        tbl[11] = '{4'b0000, 1'b0, 2'd0, 16'd0,   1'b1, 1'b0, 3'd0, 2'd0, 16'd0,   1'b0, 1'b0};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", upd_valid, 0);
        chk("rst_dir", upd_dir, 0);
        chk("rst_step", upd_step, 0);
        chk("rst_src", upd_src, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        rst_n = 1'b1;
        enable = 1'b1;
        for (int r = 0; r < 12; r++) begin
            spike_in = tbl[r].spk;
            cmd_valid = tbl[r].cv;
            cmd_dir = tbl[r].cdir;
            cmd_step = tbl[r].cstep;
            upd_ready = tbl[r].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", r), upd_valid, tbl[r].ev);
            if (tbl[r].ev) begin
                chk($sformatf("vec%0d_src", r), upd_src, tbl[r].esrc);
                chk($sformatf("vec%0d_dir", r), upd_dir, tbl[r].edir);
                chk($sformatf("vec%0d_step", r), upd_step, tbl[r].estep);
            end
            chk($sformatf("vec%0d_cmd_ready", r), cmd_ready, tbl[r].ecr);
            chk($sformatf("vec%0d_busy", r), busy, tbl[r].ebusy);
            tick();
        end
        spike_in = '0;
        cmd_valid = 1'b1;
        cmd_dir = 2'd0;
        cmd_step = 16'd9;
        upd_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("sat_cmd_inflight", upd_valid, 1);
        for (int k = 0; k < 15; k++) begin
            spike_in = 4'b0001;
            tick();
            spike_in = 4'b0000;
            tick();
        end
        chk("sat_no_ovf_at_15", overflow, 4'b0000);
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("stall_cmd_ready", cmd_ready, 0);
        tick();
        cmd_valid = 1'b0;
        spike_in = 4'b0001;
        tick();
        spike_in = 4'b0000;
        chk("sat_ovf_at_16", overflow, 4'b0001);
        chk("stall_src_hold", upd_src, 4);
        chk("stall_step_hold", upd_step, 9);
        tick();
        spike_in = 4'b0001;
        clr_overflow = 4'b0001;
        tick();
        spike_in = 4'b0000;
        clr_overflow = 4'b0000;
        chk("ovf_set_wins", overflow, 4'b0001);
        clr_overflow = 4'b0001;
        tick();
        clr_overflow = 4'b0000;
        chk("ovf_clear", overflow, 4'b0000);
        upd_ready = 1'b1;
        n0 = 0;
        n4 = 0;
        repeat (40) begin
            @(negedge clk);
            if (upd_valid && upd_src == 3'd0) n0++;
            if (upd_valid && upd_src == 3'd4) n4++;
        end
        chk("sat_spike_xfers", n0, 15);
        chk("sat_cmd_xfers", n4, 1);
        chk("sat_drained_busy", busy, 0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        enable = 1'b0;
        spike_in = 4'hF;
        tick();
        spike_in = 4'h0;
        tick();
        spike_in = 4'hF;
        tick();
        spike_in = 4'h0;
        tick();
        chk("rr_frozen_valid", upd_valid, 0);
        cmd_valid = 1'b1;
        cmd_dir = 2'd3;
        cmd_step = 16'd5;
        enable = 1'b1;
        n = 0;
        for (int c = 0; c < 30 && n < 10; c++) begin
            @(negedge clk);
            if (upd_valid) begin
                chk($sformatf("rr_src%0d", n), upd_src, rr_exp[n]);
                chk($sformatf("rr_dir%0d", n), upd_dir, rr_exp[n] == 4 ? 3 : rr_exp[n]);
                chk($sformatf("rr_step%0d", n), upd_step, rr_exp[n] == 4 ? 5 : 1);
                n++;
            end
        end
        chk("rr_count", n, 10);
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        enable = 1'b0;
        nval = 0;
        for (int k = 0; k < 16; k++) begin
            spike_in = {k < 3, 1'b1, 2'b00};
            tick();
            if (upd_valid) nval++;
            spike_in = 4'b0000;
            tick();
            if (upd_valid) nval++;
        end
        chk("gate_no_valid", nval, 0);
        chk("gate_busy", busy, 1);
        chk("gate_overflow", overflow, 4'b0100);
        upd_ready = 1'b0;
        enable = 1'b1;
        tick();
        chk("gate_release_valid", upd_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", upd_valid, 0);
        chk("async_rst_dir", upd_dir, 0);
        chk("async_rst_step", upd_step, 0);
        chk("async_rst_src", upd_src, 0);
        chk("async_rst_overflow", overflow, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_cmd_ready", cmd_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        upd_ready = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle_valid", upd_valid, 0);
        chk("post_rst_idle_busy", busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nav_update_scheduler.md
Name: nav_update_scheduler

Overview:
- Schedules and arbitrates all position-update requests for the navigation odometry accumulator.
- Requesters:
  - four spike channels (+X, +Y, -X, -Y), each with a per-channel pending-event counter;
  - one host move-command stream.
- Round-robin grants across all five sources; one update transaction at a time goes into the accumulator over a valid/ready port.
- Sits between the ui_in spike pins / register-file command path and the position datapath, so no spike edge is lost while the datapath is stalled.

Parameters:
- CNT_W, 4, width of each per-channel pending-spike counter; saturates at 2^CNT_W-1.
- STEP_W, 16, width of move step / position arithmetic.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- enable  in  1  1 = grants permitted; 0 = arbitration frozen (counting continues)
- spike_in  in  4  spike levels, synchronous to clk; bit0 +X, bit1 +Y, bit2 -X, bit3 -Y
- cmd_valid  in  1  host move command present
- cmd_dir  in  2  0 +X, 1 +Y, 2 -X, 3 -Y
- cmd_step  in  STEP_W  move magnitude
- cmd_ready  out  1  command consumed this cycle
- upd_valid  out  1  update transaction valid
- upd_ready  in  1  accumulator accepts update
- upd_dir  out  2  direction, same encoding as cmd_dir
- upd_step  out  STEP_W  magnitude (1 for spike-sourced)
- upd_src  out  3  source index: 0-3 spike channel, 4 command
- overflow  out  4  sticky per-channel spike-loss flags
- clr_overflow  in  4  write-1-to-clear for overflow bits
- busy  out  1  upd_valid OR any pending counter nonzero

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk.
- Reset values: upd_valid 0, upd_dir 0, upd_step 0, upd_src 0, overflow 0, all counters 0, previous-spike register 0, RR pointer 0. cmd_ready and busy are combinational and therefore 0 after reset.
- Edge detect:
  - rise[i] = spike_in[i] & ~prev[i]; prev is registered each cycle.
  - A rise increments cnt[i] at that clock edge.
- Saturation:
  - A rise with cnt[i] == max leaves cnt[i] at max and sets overflow[i].
  - If clr_overflow[i] and a new overflow occur in the same cycle, set wins.
- Request vector:
  - req[i] = (cnt[i] != 0) for i = 0..3; req[4] = cmd_valid.
  - All requests are masked when enable = 0.
- Output slot free when upd_valid == 0 or (upd_valid & upd_ready). A new grant is issued only when the slot is free, so a full-throughput handshake sustains one transfer per cycle.
- Grant:
  - Round-robin. Search starts at the pointer; after a grant to source k, pointer = (k+1) mod 5.
  - Pointer is unchanged when there is no grant.
- Spike grant i: cnt[i] decrements; upd_dir = i; upd_step = 1; upd_src = i.
  - Same-cycle rise and grant on one channel leaves cnt unchanged.
  - A saturated channel with both events does not set overflow.
- Command grant:
  - cmd_ready = 1 combinationally in the grant cycle.
  - upd_dir = cmd_dir, upd_step = cmd_step, upd_src = 4.
  - A command with cmd_step == 0 is consumed (cmd_ready = 1) but produces no upd_valid. The pointer still advances.
- Stall: while upd_valid & ~upd_ready, upd_dir, upd_step and upd_src hold stable and no grant occurs. cmd_ready = 0.
- Slot free with no grant: upd_valid clears.
- Latency, with enable = 1, idle slot and the channel winning arbitration:
  - spike_in rises, sampled at edge E0, so cnt = 1 after E0;
  - upd_valid = 1 after E1 (2 cycles);
  - a command presented before edge E0 yields upd_valid after E0 (1 cycle).
- enable deassert mid-operation: an in-flight transaction completes normally; counters keep accumulating; no new grant until enable = 1.
- No internal wrap: counters never wrap; STEP_W values pass through unmodified.

Decomposition:
- Package nav_pkg:
  - nav_dir_t enum (DIR_PX = 0, DIR_PY = 1, DIR_NX = 2, DIR_NY = 3);
  - constants NUM_SPIKE_CH = 4, NUM_SRC = 5, SRC_CMD = 4.
  - Shared with the odometry datapath.
- Sub-module nav_rr_arbiter: generic N-input round-robin arbiter with pointer register and one-hot grant output, instantiated with N = NUM_SRC.

Test Plan:
- Single spike: enable = 1, upd_ready = 1, pulse spike_in[1] one cycle -> upd_valid exactly one cycle, 2 cycles after rise, with dir = 1, step = 1, src = 1; then busy = 0.
- Saturation: upd_ready = 0, 16 rises on spike_in[0] -> cnt[0] = 15, overflow[0] = 1. Raise upd_ready -> exactly 15 transfers with src = 0. clr_overflow[0] -> overflow[0] = 0.
- Round-robin fairness: all 4 counters = 2 and cmd_valid held (step 5, dir 3), upd_ready = 1 -> src order 0, 1, 2, 3, 4, 0, 1, 2, 3, then cmd again.
- Backpressure: upd_ready = 0 for 10 cycles with cmd dir 2 / step 300 issued -> outputs stable; cmd_ready = 0 after the first accept; one transfer when ready rises.
- Zero-step command: cmd_step = 0 -> cmd_ready pulses, no upd_valid. Next spike request is then granted normally.
- Enable gating and reset: enable = 0, 3 rises on ch 3 -> no upd_valid, cnt[3] = 3. Assert rst_n low mid-burst -> all outputs return to reset values immediately.
